// File: rtl/falafel_pkg.sv
// Shared types and constants for the falafel allocator: LSU operations,
// the free-block layout and the allocation size helper.
package falafel_pkg;

  localparam int DATA_W    = 32;
  localparam int WORD_SIZE = 4;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [DATA_W:0]   wide_t;

  localparam word_t NULL_PTR   = '0;
  localparam word_t ALLOC_FAIL = NULL_PTR;

  typedef enum logic [2:0] {
    LSU_OP_LOAD_WORD   = 3'd0,
    LSU_OP_LOAD_BLOCK  = 3'd1,
    LSU_OP_STORE_WORD  = 3'd2,
    LSU_OP_STORE_BLOCK = 3'd3,
    LSU_OP_LOCK        = 3'd4,
    LSU_OP_UNLOCK      = 3'd5
  } lsu_op_e;

  typedef struct packed {
    word_t size;
    word_t next_ptr;
  } free_block_t;

  typedef struct packed {
    logic  ovf;
    word_t need;
  } need_t;

  // Block bytes for a payload: word-rounded payload plus the size header.
  // Computed one bit wider so any carry out marks the request as unservable.
  function automatic need_t calc_need(input word_t size);
    wide_t sum;
    need_t res;
    sum = wide_t'(size) + wide_t'(WORD_SIZE - 1);
    sum[$clog2(WORD_SIZE)-1:0] = '0;
    sum = sum + wide_t'(WORD_SIZE);
    res.ovf  = sum[DATA_W];
    res.need = sum[DATA_W-1:0];
    if (res.need < word_t'(2 * WORD_SIZE)) res.need = word_t'(2 * WORD_SIZE);
    return res;
  endfunction

endpackage

// File: rtl/falafel_alloc_walker.sv
// First-fit allocator: locks the free list, walks it through the LSU,
// splits or unlinks the first fitting block and returns its payload pointer.
module falafel_alloc_walker
  import falafel_pkg::*;
#(
  parameter word_t HEAD_ADDR = 32'h0000_0100,
  parameter word_t LOCK_ID   = 32'h1,
  parameter int    MIN_SPLIT = 16,
  parameter int    MAX_WALK  = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_val_i,
  output logic        req_rdy_o,
  input  word_t       req_size_i,
  output logic        rsp_val_o,
  input  logic        rsp_rdy_i,
  output word_t       rsp_addr_o,
  output logic        lsu_req_val_o,
  input  logic        lsu_req_rdy_i,
  output lsu_op_e     lsu_req_op_o,
  output word_t       lsu_req_addr_o,
  output word_t       lsu_req_word_o,
  output word_t       lsu_req_lock_id_o,
  output free_block_t lsu_req_block_o,
  input  logic        lsu_rsp_val_i,
  output logic        lsu_rsp_rdy_o,
  input  word_t       lsu_rsp_word_i,
  input  free_block_t lsu_rsp_block_i
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_LOCK     = 4'd1;
  localparam logic [3:0] S_LD_HEAD  = 4'd2;
  localparam logic [3:0] S_CHECK    = 4'd3;
  localparam logic [3:0] S_LD_BLK   = 4'd4;
  localparam logic [3:0] S_FIT      = 4'd5;
  localparam logic [3:0] S_ST_SPLIT = 4'd6;
  localparam logic [3:0] S_ST_LINK  = 4'd7;
  localparam logic [3:0] S_ST_SIZE  = 4'd8;
  localparam logic [3:0] S_UNLOCK   = 4'd9;
  localparam logic [3:0] S_RESPOND  = 4'd10;

  function automatic logic is_lsu_state(input logic [3:0] s);
    return (s == S_LOCK) || (s == S_LD_HEAD) || (s == S_LD_BLK) || (s == S_ST_SPLIT) ||
           (s == S_ST_LINK) || (s == S_ST_SIZE) || (s == S_UNLOCK);
  endfunction

  logic [3:0]  r_state, w_state_n;
  word_t       r_need, w_need_n, r_curr, w_curr_n, r_prev, w_prev_n;
  word_t       r_link, w_link_n, r_walk, w_walk_n;
  free_block_t r_blk, w_blk_n;
  logic        r_prev_is_head, w_prev_is_head_n, r_split, w_split_n, r_fail, w_fail_n;
  logic        r_issued;
  need_t       w_need_calc;
  logic        w_lsu_done, w_launch;
  lsu_op_e     w_op;
  word_t       w_addr, w_word;
  free_block_t w_blk_req;

  logic        r_rsp_val, r_lsu_req_val, r_lsu_rsp_rdy;
  word_t       r_rsp_addr, r_lsu_req_addr, r_lsu_req_word, r_lsu_req_lock_id;
  lsu_op_e     r_lsu_req_op;
  free_block_t r_lsu_req_block;

  assign w_need_calc = calc_need(req_size_i);
  assign w_lsu_done  = r_issued && r_lsu_rsp_rdy && lsu_rsp_val_i;

  always_comb begin
    w_state_n        = r_state;
    w_need_n         = r_need;
    w_curr_n         = r_curr;
    w_prev_n         = r_prev;
    w_link_n         = r_link;
    w_walk_n         = r_walk;
    w_blk_n          = r_blk;
    w_prev_is_head_n = r_prev_is_head;
    w_split_n        = r_split;
    w_fail_n         = r_fail;
    case (r_state)
      S_IDLE: if (req_val_i) begin
        w_need_n = w_need_calc.need;
        // Zero-size and overflowing requests fail without touching the lock.
        if (req_size_i == '0 || w_need_calc.ovf) begin
          w_fail_n  = 1'b1;
          w_state_n = S_RESPOND;
        end else begin
          w_fail_n  = 1'b0;
          w_state_n = S_LOCK;
        end
      end
      S_LOCK: if (w_lsu_done) w_state_n = S_LD_HEAD;
      S_LD_HEAD: if (w_lsu_done) begin
        w_curr_n         = lsu_rsp_word_i;
        w_prev_is_head_n = 1'b1;
        w_walk_n         = '0;
        w_state_n        = S_CHECK;
      end
      S_CHECK: begin
        if (r_curr == NULL_PTR || r_walk == word_t'(MAX_WALK)) begin
          w_fail_n  = 1'b1;
          w_state_n = S_UNLOCK;
        end else begin
          w_state_n = S_LD_BLK;
        end
      end
      S_LD_BLK: if (w_lsu_done) begin
        w_blk_n   = lsu_rsp_block_i;
        w_state_n = S_FIT;
      end
      S_FIT: begin
        if (r_blk.size < r_need) begin
          w_prev_n         = r_curr;
          w_prev_is_head_n = 1'b0;
          w_curr_n         = r_blk.next_ptr;
          w_walk_n         = r_walk + 1'b1;
          w_state_n        = S_CHECK;
        end else if (r_blk.size - r_need >= word_t'(MIN_SPLIT)) begin
          w_split_n = 1'b1;
          w_state_n = S_ST_SPLIT;
        end else begin
          w_split_n = 1'b0;
          w_link_n  = r_blk.next_ptr;
          w_state_n = S_ST_LINK;
        end
      end
      S_ST_SPLIT: if (w_lsu_done) begin
        w_link_n  = r_curr + r_need;
        w_state_n = S_ST_LINK;
      end
      S_ST_LINK: if (w_lsu_done) w_state_n = r_split ? S_ST_SIZE : S_UNLOCK;
      S_ST_SIZE: if (w_lsu_done) w_state_n = S_UNLOCK;
      S_UNLOCK:  if (w_lsu_done) w_state_n = S_RESPOND;
      S_RESPOND: if (rsp_rdy_i) w_state_n = S_IDLE;
      default:   w_state_n = S_IDLE;
    endcase
  end

  // Request fields are built from next-state values so each op issues on state entry.
  always_comb begin
    w_launch  = (w_state_n != r_state) && is_lsu_state(w_state_n);
    w_op      = LSU_OP_LOAD_WORD;
    w_addr    = '0;
    w_word    = '0;
    w_blk_req = '0;
    case (w_state_n)
      S_LOCK:    w_op = LSU_OP_LOCK;
      S_LD_HEAD: w_addr = HEAD_ADDR;
      S_LD_BLK: begin
        w_op   = LSU_OP_LOAD_BLOCK;
        w_addr = w_curr_n;
      end
      S_ST_SPLIT: begin
        w_op               = LSU_OP_STORE_BLOCK;
        w_addr             = w_curr_n + w_need_n;
        w_blk_req.size     = w_blk_n.size - w_need_n;
        w_blk_req.next_ptr = w_blk_n.next_ptr;
      end
      S_ST_LINK: begin
        w_op   = LSU_OP_STORE_WORD;
        w_addr = w_prev_is_head_n ? HEAD_ADDR : w_prev_n + word_t'(WORD_SIZE);
        w_word = w_link_n;
      end
      S_ST_SIZE: begin
        w_op   = LSU_OP_STORE_WORD;
        w_addr = w_curr_n;
        w_word = w_need_n;
      end
      S_UNLOCK: w_op = LSU_OP_UNLOCK;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state           <= S_IDLE;
      r_need            <= '0;
      r_curr            <= '0;
      r_prev            <= '0;
      r_link            <= '0;
      r_walk            <= '0;
      r_blk             <= '0;
      r_prev_is_head    <= 1'b0;
      r_split           <= 1'b0;
      r_fail            <= 1'b0;
      r_issued          <= 1'b0;
      r_rsp_val         <= 1'b0;
      r_rsp_addr        <= NULL_PTR;
      r_lsu_req_val     <= 1'b0;
      r_lsu_rsp_rdy     <= 1'b0;
      r_lsu_req_op      <= LSU_OP_LOAD_WORD;
      r_lsu_req_addr    <= '0;
      r_lsu_req_word    <= '0;
      r_lsu_req_lock_id <= '0;
      r_lsu_req_block   <= '0;
    end else begin
      r_state        <= w_state_n;
      r_need         <= w_need_n;
      r_curr         <= w_curr_n;
      r_prev         <= w_prev_n;
      r_link         <= w_link_n;
      r_walk         <= w_walk_n;
      r_blk          <= w_blk_n;
      r_prev_is_head <= w_prev_is_head_n;
      r_split        <= w_split_n;
      r_fail         <= w_fail_n;
      // Two-phase LSU op: issue until accepted, then wait for the response.
      if (w_launch) begin
        r_lsu_req_val     <= 1'b1;
        r_lsu_rsp_rdy     <= 1'b0;
        r_issued          <= 1'b0;
        r_lsu_req_op      <= w_op;
        r_lsu_req_addr    <= w_addr;
        r_lsu_req_word    <= w_word;
        r_lsu_req_lock_id <= LOCK_ID;
        r_lsu_req_block   <= w_blk_req;
      end else if (r_lsu_req_val && lsu_req_rdy_i) begin
        r_lsu_req_val <= 1'b0;
        r_lsu_rsp_rdy <= 1'b1;
        r_issued      <= 1'b1;
      end else if (w_lsu_done) begin
        r_lsu_rsp_rdy <= 1'b0;
        r_issued      <= 1'b0;
      end
      r_rsp_val <= (w_state_n == S_RESPOND);
      if (w_state_n == S_RESPOND && r_state != S_RESPOND)
        r_rsp_addr <= w_fail_n ? ALLOC_FAIL : r_curr + word_t'(WORD_SIZE);
    end
  end

  assign req_rdy_o         = (r_state == S_IDLE);
  assign rsp_val_o         = r_rsp_val;
  assign rsp_addr_o        = r_rsp_addr;
  assign lsu_req_val_o     = r_lsu_req_val;
  assign lsu_req_op_o      = r_lsu_req_op;
  assign lsu_req_addr_o    = r_lsu_req_addr;
  assign lsu_req_word_o    = r_lsu_req_word;
  assign lsu_req_lock_id_o = r_lsu_req_lock_id;
  assign lsu_req_block_o   = r_lsu_req_block;
  assign lsu_rsp_rdy_o     = r_lsu_rsp_rdy;

endmodule

// File: tb/tb_falafel_alloc_walker.sv
// Scoreboard bench for falafel_alloc_walker with a behavioural LSU/memory model.
module tb_falafel_alloc_walker;
  import falafel_pkg::*;

  logic        clk;
  logic        rst_ni;
  logic        req_val_i;
  logic        req_rdy_o;
  word_t       req_size_i;
  logic        rsp_val_o;
  logic        rsp_rdy_i;
  word_t       rsp_addr_o;
  logic        lsu_req_val_o;
  logic        lsu_req_rdy_i;
  lsu_op_e     lsu_req_op_o;
  word_t       lsu_req_addr_o;
  word_t       lsu_req_word_o;
  word_t       lsu_req_lock_id_o;
  free_block_t lsu_req_block_o;
  logic        lsu_rsp_val_i;
  logic        lsu_rsp_rdy_o;
  word_t       lsu_rsp_word_i;
  free_block_t lsu_rsp_block_i;

  falafel_alloc_walker dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_val_i(req_val_i), .req_rdy_o(req_rdy_o), .req_size_i(req_size_i),
    .rsp_val_o(rsp_val_o), .rsp_rdy_i(rsp_rdy_i), .rsp_addr_o(rsp_addr_o),
    .lsu_req_val_o(lsu_req_val_o), .lsu_req_rdy_i(lsu_req_rdy_i),
    .lsu_req_op_o(lsu_req_op_o), .lsu_req_addr_o(lsu_req_addr_o),
    .lsu_req_word_o(lsu_req_word_o), .lsu_req_lock_id_o(lsu_req_lock_id_o),
    .lsu_req_block_o(lsu_req_block_o),
    .lsu_rsp_val_i(lsu_rsp_val_i), .lsu_rsp_rdy_o(lsu_rsp_rdy_o),
    .lsu_rsp_word_i(lsu_rsp_word_i), .lsu_rsp_block_i(lsu_rsp_block_i)
  );

  typedef struct {
    lsu_op_e     op;
    word_t       addr;
    word_t       word;
    free_block_t blk;
  } exp_t;

  exp_t  lsu_q[$];
  word_t rsp_q[$];
  word_t mem [word_t];
  int    checks = 0;
  int    errors = 0;
  int    rsp_cnt = 0;
  logic  mon_en = 1'b1;
  logic  stall_arm = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic word_t rd(input word_t a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  task automatic push_op(input lsu_op_e op, input word_t addr, input word_t word,
                         input word_t bsz, input word_t bnext);
    exp_t e;
    e.op = op; e.addr = addr; e.word = word;
    e.blk.size = bsz; e.blk.next_ptr = bnext;
    lsu_q.push_back(e);
  endtask

  task automatic init_mem(input logic cyclic);
    mem.delete();
    mem[32'h100]  = 32'h1000;
    mem[32'h1000] = 32'd64;
    mem[32'h1004] = 32'h2000;
    mem[32'h2000] = 32'd256;
    mem[32'h2004] = cyclic ? 32'h1000 : NULL_PTR;
  endtask

  // LSU model: accepts immediately (unless stalling) and answers one cycle later.
  initial begin : lsu_model
    logic        p_req, p_rsp;
    lsu_op_e     c_op;
    word_t       c_addr, c_word;
    free_block_t c_blk;
    int          stall_left;
    p_req = 1'b0; p_rsp = 1'b0; stall_left = 0;
    c_op = LSU_OP_LOAD_WORD; c_addr = '0; c_word = '0; c_blk = '0;
    lsu_req_rdy_i = 1'b1; lsu_rsp_val_i = 1'b0;
    lsu_rsp_word_i = '0; lsu_rsp_block_i = '0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        lsu_rsp_val_i = 1'b0; lsu_req_rdy_i = 1'b1;
        p_req = 1'b0; p_rsp = 1'b0; stall_left = 0;
      end else begin
        if (p_rsp) lsu_rsp_val_i = 1'b0;
        if (p_req) begin
          case (c_op)
            LSU_OP_LOAD_WORD:   lsu_rsp_word_i = rd(c_addr);
            LSU_OP_LOAD_BLOCK: begin
              lsu_rsp_block_i.size     = rd(c_addr);
              lsu_rsp_block_i.next_ptr = rd(c_addr + 32'd4);
            end
            LSU_OP_STORE_WORD:  mem[c_addr] = c_word;
            LSU_OP_STORE_BLOCK: begin
              mem[c_addr]         = c_blk.size;
              mem[c_addr + 32'd4] = c_blk.next_ptr;
            end
            default: ;
          endcase
          lsu_rsp_val_i = 1'b1;
        end
        if (stall_arm && stall_left == 0 && lsu_req_val_o && lsu_req_op_o == LSU_OP_LOAD_BLOCK)
          stall_left = 5;
        if (stall_left > 0) begin
          lsu_req_rdy_i = 1'b0;
          check("stall_val", 64'(lsu_req_val_o), 64'd1);
          check("stall_op", 64'(lsu_req_op_o), 64'(LSU_OP_LOAD_BLOCK));
          check("stall_addr", 64'(lsu_req_addr_o), 64'h1000);
          stall_left--;
          if (stall_left == 0) stall_arm = 1'b0;
        end else begin
          lsu_req_rdy_i = 1'b1;
        end
        p_req  = lsu_req_val_o && lsu_req_rdy_i;
        c_op   = lsu_req_op_o; c_addr = lsu_req_addr_o;
        c_word = lsu_req_word_o; c_blk = lsu_req_block_o;
        p_rsp  = lsu_rsp_val_i && lsu_rsp_rdy_o;
      end
    end
  end

  // Monitor: compares every accepted LSU request and every delivered response.
  initial begin : monitor
    exp_t e;
    word_t ea;
    forever begin
      @(negedge clk);
      #1;
      if (rst_ni && mon_en && lsu_req_val_o && lsu_req_rdy_i) begin
        if (lsu_q.size() == 0) begin
          check("lsu_unexpected_op", 64'(lsu_req_op_o), 64'hFFFF);
        end else begin
          e = lsu_q.pop_front();
          check("lsu_op", 64'(lsu_req_op_o), 64'(e.op));
          if (e.op != LSU_OP_LOCK && e.op != LSU_OP_UNLOCK)
            check("lsu_addr", 64'(lsu_req_addr_o), 64'(e.addr));
          else
            check("lsu_lock_id", 64'(lsu_req_lock_id_o), 64'h1);
          if (e.op == LSU_OP_STORE_WORD)  check("lsu_word", 64'(lsu_req_word_o), 64'(e.word));
          if (e.op == LSU_OP_STORE_BLOCK) check("lsu_block", lsu_req_block_o, e.blk);
        end
      end
      if (rst_ni && rsp_val_o && rsp_rdy_i) begin
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", 64'(rsp_addr_o), 64'hFFFF_FFFF_FFFF);
        end else begin
          ea = rsp_q.pop_front();
          check("rsp_addr", 64'(rsp_addr_o), 64'(ea));
        end
        rsp_cnt++;
      end
    end
  end

  task automatic do_req(input word_t sz);
    int n;
    @(negedge clk);
    req_val_i = 1'b1; req_size_i = sz;
    n = 0;
    while (!req_rdy_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("req_accept_timeout", 64'd0, 64'd1);
    @(negedge clk);
    req_val_i = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input int c0, input int budget);
    int n;
    n = 0;
    while (rsp_cnt == c0 && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    check(name, 64'(rsp_cnt - c0), 64'd1);
  endtask

  task automatic push_test1;
    push_op(LSU_OP_LOCK, 0, 0, 0, 0);
    push_op(LSU_OP_LOAD_WORD, 32'h100, 0, 0, 0);
    push_op(LSU_OP_LOAD_BLOCK, 32'h1000, 0, 0, 0);
    push_op(LSU_OP_STORE_BLOCK, 32'h1014, 0, 32'd44, 32'h2000);
    push_op(LSU_OP_STORE_WORD, 32'h100, 32'h1014, 0, 0);
    push_op(LSU_OP_STORE_WORD, 32'h1000, 32'd20, 0, 0);
    push_op(LSU_OP_UNLOCK, 0, 0, 0, 0);
    rsp_q.push_back(32'h1004);
  endtask

  task automatic run_test(input string name, input word_t sz, input int budget);
    int c0;
    c0 = rsp_cnt;
    do_req(sz);
    wait_rsp({name, "_rsp"}, c0, budget);
    check({name, "_lsu_left"}, 64'(lsu_q.size()), 64'd0);
  endtask

  initial begin : stim
    int n;
    rsp_rdy_i = 1'b1; req_val_i = 1'b0; req_size_i = '0;
    rst_ni = 1'b0;
    init_mem(1'b0);
    #12;
    check("rst_rsp_val", 64'(rsp_val_o), 64'd0);
    check("rst_lsu_req_val", 64'(lsu_req_val_o), 64'd0);
    check("rst_lsu_rsp_rdy", 64'(lsu_rsp_rdy_o), 64'd0);
    check("rst_rsp_addr", 64'(rsp_addr_o), 64'd0);
    check("rst_lsu_op", 64'(lsu_req_op_o), 64'(LSU_OP_LOAD_WORD));
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    check("rst_req_rdy", 64'(req_rdy_o), 64'd1);

    // Test 1: first-block hit with split.
    init_mem(1'b0);
    push_test1();
    run_test("t1", 32'd16, 100);

    // Test 2: exact fit, unlink from head.
    init_mem(1'b0);
    push_op(LSU_OP_LOCK, 0, 0, 0, 0);
    push_op(LSU_OP_LOAD_WORD, 32'h100, 0, 0, 0);
    push_op(LSU_OP_LOAD_BLOCK, 32'h1000, 0, 0, 0);
    push_op(LSU_OP_STORE_WORD, 32'h100, 32'h2000, 0, 0);
    push_op(LSU_OP_UNLOCK, 0, 0, 0, 0);
    rsp_q.push_back(32'h1004);
    run_test("t2", 32'd60, 100);

    // Test 3: skip first block, split second and link through prev.
    init_mem(1'b0);
    push_op(LSU_OP_LOCK, 0, 0, 0, 0);
    push_op(LSU_OP_LOAD_WORD, 32'h100, 0, 0, 0);
    push_op(LSU_OP_LOAD_BLOCK, 32'h1000, 0, 0, 0);
    push_op(LSU_OP_LOAD_BLOCK, 32'h2000, 0, 0, 0);
    push_op(LSU_OP_STORE_BLOCK, 32'h2068, 0, 32'd152, 32'h0);
    push_op(LSU_OP_STORE_WORD, 32'h1004, 32'h2068, 0, 0);
    push_op(LSU_OP_STORE_WORD, 32'h2000, 32'd104, 0, 0);
    push_op(LSU_OP_UNLOCK, 0, 0, 0, 0);
    rsp_q.push_back(32'h2004);
    run_test("t3", 32'd100, 100);

    // Test 4: nothing fits, walk to NULL.
    init_mem(1'b0);
    push_op(LSU_OP_LOCK, 0, 0, 0, 0);
    push_op(LSU_OP_LOAD_WORD, 32'h100, 0, 0, 0);
    push_op(LSU_OP_LOAD_BLOCK, 32'h1000, 0, 0, 0);
    push_op(LSU_OP_LOAD_BLOCK, 32'h2000, 0, 0, 0);
    push_op(LSU_OP_UNLOCK, 0, 0, 0, 0);
    rsp_q.push_back(NULL_PTR);
    run_test("t4", 32'd1000, 100);

    // Test 4b: cyclic list stops after MAX_WALK (1024) block visits.
    init_mem(1'b1);
    push_op(LSU_OP_LOCK, 0, 0, 0, 0);
    push_op(LSU_OP_LOAD_WORD, 32'h100, 0, 0, 0);
    for (int i = 0; i < 1024; i++)
      push_op(LSU_OP_LOAD_BLOCK, (i % 2 == 0) ? 32'h1000 : 32'h2000, 0, 0, 0);
    push_op(LSU_OP_UNLOCK, 0, 0, 0, 0);
    rsp_q.push_back(NULL_PTR);
    run_test("t4_cyclic", 32'd1000, 8000);

    // Test 5: zero-size request, response within 2 cycles of acceptance.
    rsp_q.push_back(NULL_PTR);
    run_test("t5_zero", 32'd0, 2);

    // Test 5b: LSU stalls LOAD_BLOCK acceptance for 5 cycles.
    init_mem(1'b0);
    stall_arm = 1'b1;
    push_test1();
    run_test("t5_stall", 32'd16, 100);
    check("t5_stall_done", 64'(stall_arm), 64'd0);

    // Test 6: asynchronous reset during the ST_SPLIT response phase.
    init_mem(1'b0);
    mon_en = 1'b0;
    do_req(32'd16);
    n = 0;
    while (!(lsu_rsp_rdy_o && lsu_req_op_o == LSU_OP_STORE_BLOCK) && n < 100) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("t6_reach_split", 64'(n < 100), 64'd1);
    rst_ni = 1'b0;
    #1;
    check("t6_rsp_val", 64'(rsp_val_o), 64'd0);
    check("t6_lsu_req_val", 64'(lsu_req_val_o), 64'd0);
    check("t6_lsu_rsp_rdy", 64'(lsu_rsp_rdy_o), 64'd0);
    check("t6_rsp_addr", 64'(rsp_addr_o), 64'd0);
    check("t6_lsu_op", 64'(lsu_req_op_o), 64'(LSU_OP_LOAD_WORD));
    check("t6_lsu_addr", 64'(lsu_req_addr_o), 64'd0);
    check("t6_lsu_lock_id", 64'(lsu_req_lock_id_o), 64'd0);
    check("t6_lsu_block", lsu_req_block_o, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check("t6_req_rdy", 64'(req_rdy_o), 64'd1);
    init_mem(1'b0);
    push_test1();
    run_test("t6_rerun", 32'd16, 100);

    repeat (3) @(negedge clk);
    check("rsp_q_left", 64'(rsp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
